seq_controller: RTL and testbench

Parametrised multi-cycle control FSM for the 16-bit CPU, and the successor of the current controller. It sequences fetch, decode, execute and data-memory write-back, and drives the register load, PC, ALU-mode, mux-select and data-memory write strobes. Over the current controller it adds:
- single-cycle write pulses
- a data-memory ready handshake with timeout
- a halt request
- a sticky error state
- parametrised opcode and timer widths

---
 rtl/seq_controller_pkg.sv | 17 +
 rtl/seq_controller_wait_timer.sv | 29 ++
 rtl/seq_controller.sv | 106 ++++++++++
 tb/tb_seq_controller.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/seq_controller_pkg.sv
// seq_ctrl_pkg: state encoding, opcode constants and ALU-class decode shared by seq_controller.
//   state_t      : controller states
//   OP_*         : 4-bit opcodes of the load and jump instructions
//   alu_decode() : returns {is_alu, mode} for a 4-bit opcode
package seq_ctrl_pkg;
    typedef enum logic [2:0] {
        IDLE, FETCH, DECODE, EXEC, MEM_WAIT, HALTCHK, HALT, ERROR
    } state_t;
    localparam logic [3:0] OP_LDA = 4'b0100;
    localparam logic [3:0] OP_LDB = 4'b0101;
    localparam logic [3:0] OP_LDC = 4'b0110;
    localparam logic [3:0] OP_JMP = 4'b0111;
    // 0000-0011 is the mode-0 ALU group, 1xxx the mode-1 ALU group
    function automatic logic [1:0] alu_decode(input logic [3:0] op);
        return {op[3] | (op[3:2] == 2'b00), op[3]};
    endfunction
endpackage

// File: rtl/seq_controller_wait_timer.sv
// wait_timer: counts data-memory wait cycles for seq_controller.
//   clk, rst    : clock, asynchronous active-high reset
//   i_clr       : synchronous clear (wins over i_en)
//   i_en        : count up by one
//   o_first     : count is 1 (first wait cycle)
//   o_expired   : count has reached TIMEOUT
module wait_timer #(
    parameter int WAIT_W  = 4,
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_first,
    output logic o_expired
);
    logic [WAIT_W-1:0] r_cnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= '0;
        else if (i_en)
            r_cnt <= r_cnt + 1'b1;
    end
    assign o_first   = r_cnt == WAIT_W'(1);
    assign o_expired = r_cnt == WAIT_W'(TIMEOUT);
endmodule

// File: rtl/seq_controller.sv
// seq_controller: multi-cycle fetch/decode/execute/write-back control FSM for the 16-bit CPU.
//   clk, rst        : clock, asynchronous active-high reset
//   en              : run enable; low zeroes all outputs and returns to IDLE
//   opcode          : IR opcode field (bits above [3:0] must be zero)
//   mem_ready       : data-memory write acknowledge
//   halt_req        : stop before the next fetch
//   zero_flag       : ALU zero flag, used by conditional jumps
//   load_a/b/c/ir   : register load strobes
//   load_pc, inc_pc : PC load / increment
//   mode            : ALU mode
//   we_dm           : data-memory write strobe (one cycle per ALU instruction)
//   sel_a, sel_b    : operand mux selects
//   halted, err     : in HALT / in ERROR
// Build option: define COND_JMP_EN to make opcode 0111 jump only when zero_flag is set.
module seq_controller #(
    parameter int OP_W    = 4,
    parameter int WAIT_W  = 4,
    parameter int TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [OP_W-1:0] opcode,
    input  logic            mem_ready,
    input  logic            halt_req,
    input  logic            zero_flag,
    output logic            load_a,
    output logic            load_b,
    output logic            load_c,
    output logic            load_ir,
    output logic            load_pc,
    output logic            inc_pc,
    output logic            mode,
    output logic            we_dm,
    output logic            sel_a,
    output logic            sel_b,
    output logic            halted,
    output logic            err
);
    import seq_ctrl_pkg::*;

    state_t     r_state;
    logic [3:0] w_op;
    logic [1:0] w_dec;
    logic       w_illegal, w_is_alu, w_exec, w_mw, w_tmr_run, w_first, w_expired, w_jump;

    assign w_op      = opcode[3:0];
    assign w_illegal = (opcode >> 4) != '0;
    assign w_dec     = alu_decode(w_op);
    assign w_is_alu  = w_dec[1];

`ifdef COND_JMP_EN
    assign w_jump = zero_flag;
`else
    logic w_unused_zf;
    assign w_unused_zf = zero_flag;
    assign w_jump      = 1'b1;
`endif

    // The timer reaches 1 on the first MEM_WAIT cycle because it starts counting in EXEC.
    assign w_tmr_run = en && ((r_state == EXEC && w_is_alu) || r_state == MEM_WAIT);

    wait_timer #(.WAIT_W(WAIT_W), .TIMEOUT(TIMEOUT)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (!w_tmr_run),
        .i_en      (w_tmr_run),
        .o_first   (w_first),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= IDLE;
        else if (!en)
            r_state <= IDLE;
        else
            case (r_state)
                IDLE:          r_state <= FETCH;
                FETCH:         r_state <= DECODE;
                DECODE:        r_state <= w_illegal ? ERROR : EXEC;
                EXEC:          r_state <= w_is_alu ? MEM_WAIT : HALTCHK;
                MEM_WAIT:      r_state <= mem_ready ? HALTCHK : (w_expired ? ERROR : MEM_WAIT);
                HALTCHK, HALT: r_state <= halt_req ? HALT : FETCH;
                ERROR:         r_state <= ERROR;
                default:       r_state <= IDLE;
            endcase
    end

    assign w_exec  = en && r_state == EXEC;
    assign w_mw    = en && r_state == MEM_WAIT;
    assign load_ir = en && r_state == FETCH;
    assign load_a  = w_exec && w_op == OP_LDA;
    assign load_b  = w_exec && w_op == OP_LDB;
    assign load_c  = w_exec && w_op == OP_LDC;
    assign load_pc = w_exec && w_op == OP_JMP && w_jump;
    assign sel_a   = load_pc;
    assign sel_b   = load_pc;
    // A not-taken conditional jump just steps over the instruction.
    assign inc_pc  = load_a || load_b || load_c || (w_exec && w_op == OP_JMP && !w_jump)
                     || (w_mw && mem_ready);
    assign mode    = (w_exec || w_mw) && w_is_alu && w_dec[0];
    assign we_dm   = w_mw && w_first;
    assign halted  = en && r_state == HALT;
    assign err     = en && r_state == ERROR;
endmodule

// File: tb/tb_seq_controller.sv
// tb_seq_controller: randomized instruction stream checked against a per-instruction cycle schedule.
`timescale 1ns/1ps
module tb_seq_controller;
    localparam int TIMEOUT = 15;
    localparam int LA = 11, LB = 10, LC = 9, IR = 8, PC = 7, INC = 6, MD = 5, WE = 4, SA = 3, SB = 2, HL = 1, ER = 0;

    typedef struct packed {
        logic        en, mr, hr, zf;
        logic [3:0]  op;
        logic [11:0] exp;
    } cyc_t;

    logic        clk = 1'b0, rst = 1'b1, en = 1'b0, mem_ready = 1'b0, halt_req = 1'b0, zero_flag = 1'b0;
    logic [3:0]  opcode = '0;
    logic        load_a, load_b, load_c, load_ir, load_pc, inc_pc, mode, we_dm, sel_a, sel_b, halted, err;
    logic [11:0] outs;
    logic        en6 = 1'b0;
    logic [5:0]  opcode6 = '0;
    logic [11:0] o6;
    logic [11:0] w6_exp [9] = '{12'h000, 12'h100, 12'h000, 12'h840, 12'h000, 12'h100, 12'h000, 12'h001, 12'h001};
    int          total = 0, bad = 0;
    cyc_t        q[$];

    always #5 clk = ~clk;

    assign outs = {load_a, load_b, load_c, load_ir, load_pc, inc_pc, mode, we_dm, sel_a, sel_b, halted, err};

    seq_controller #(.OP_W(4), .WAIT_W(4), .TIMEOUT(TIMEOUT)) u_dut (
        .clk(clk), .rst(rst), .en(en), .opcode(opcode), .mem_ready(mem_ready),
        .halt_req(halt_req), .zero_flag(zero_flag),
        .load_a(load_a), .load_b(load_b), .load_c(load_c), .load_ir(load_ir),
        .load_pc(load_pc), .inc_pc(inc_pc), .mode(mode), .we_dm(we_dm),
        .sel_a(sel_a), .sel_b(sel_b), .halted(halted), .err(err)
    );

    seq_controller #(.OP_W(6), .WAIT_W(4), .TIMEOUT(TIMEOUT)) u_w6 (
        .clk(clk), .rst(rst), .en(en6), .opcode(opcode6), .mem_ready(1'b0),
        .halt_req(1'b0), .zero_flag(1'b0),
        .load_a(o6[11]), .load_b(o6[10]), .load_c(o6[9]), .load_ir(o6[8]),
        .load_pc(o6[7]), .inc_pc(o6[6]), .mode(o6[5]), .we_dm(o6[4]),
        .sel_a(o6[3]), .sel_b(o6[2]), .halted(o6[1]), .err(o6[0])
    );

    task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] b(input int p);
        return 12'(1) << p;
    endfunction

    function automatic logic rb();
        return $urandom_range(0, 1) == 1;
    endfunction

    task automatic push(input logic e, input logic mr, input logic hr, input logic zf,
                        input logic [3:0] op, input logic [11:0] x);
        cyc_t c;
        c.en = e; c.mr = mr; c.hr = hr; c.zf = zf; c.op = op; c.exp = x;
        q.push_back(c);
    endtask

    // Expected cycles of one instruction starting at FETCH; rdy is the MEM_WAIT cycle
    // carrying mem_ready (beyond TIMEOUT means never), zx forces zero_flag in EXEC (-1 random).
    task automatic gen_instr(input logic [3:0] op, input int rdy, input bit hlt, input int hold,
                             input int zx, input bit abort);
        int          start = q.size();
        int          n_err;
        logic        z;
        logic [11:0] x;
        bit          alu, done;
        alu = (op < 4) || op[3];
        push(1'b1, rb(), rb(), rb(), 4'($urandom), b(IR));
        push(1'b1, rb(), rb(), rb(), op, '0);
        z = (zx < 0) ? rb() : zx[0];
        x = (alu && op[3]) ? b(MD) : 12'h0;
        if (op inside {4, 5, 6}) x = b(op == 4 ? LA : op == 5 ? LB : LC) | b(INC);
        if (op == 7) begin
`ifdef COND_JMP_EN
            x = z ? (b(PC) | b(SA) | b(SB)) : b(INC);
`else
            x = b(PC) | b(SA) | b(SB);
`endif
        end
        push(1'b1, rb(), rb(), z, op, x);
        done = !alu;
        for (int k = 1; alu && k <= TIMEOUT && !done; k++) begin
            done = (k == rdy);
            push(1'b1, done, rb(), rb(), op,
                 (op[3] ? b(MD) : 12'h0) | (k == 1 ? b(WE) : 12'h0) | (done ? b(INC) : 12'h0));
        end
        if (!done) begin
            n_err = $urandom_range(1, 4);
            for (int i = 0; i < n_err; i++) push(1'b1, rb(), rb(), rb(), op, b(ER));
            push(1'b0, rb(), rb(), rb(), op, '0);
            push(1'b1, rb(), rb(), rb(), op, '0);
        end else begin
            push(1'b1, rb(), hlt, rb(), op, '0);
            for (int i = 0; i < (hlt ? hold : 0); i++) push(1'b1, rb(), i < hold - 1, rb(), op, b(HL));
        end
        if (abort) begin
            int cut;
            cut = $urandom_range(q.size() - 1, start);
            while (q.size() > cut) void'(q.pop_back());
            push(1'b0, rb(), rb(), rb(), op, '0);
            push(1'b1, rb(), rb(), rb(), op, '0);
        end
    endtask

    task automatic play(input int n);
        cyc_t c;
        for (int i = 0; i < n && q.size() > 0; i++) begin
            c = q.pop_front();
            en = c.en; mem_ready = c.mr; halt_req = c.hr; zero_flag = c.zf; opcode = c.op;
            #1 chk($sformatf("cyc%0d", total), outs, c.exp);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc_t c;
        #2 chk("rst_outs", outs, '0);
        en = 1'b1;
        #1 chk("rst_en_high", outs, '0);
        @(posedge clk); #1;
        chk("rst_held", outs, '0);
        rst = 1'b0;
        push(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, '0);
        gen_instr(4'd4, 0, 0, 0, -1, 0);
        gen_instr(4'd10, 3, 0, 0, -1, 0);
        gen_instr(4'd1, 99, 0, 0, -1, 0);
        gen_instr(4'd5, 0, 1, 5, -1, 0);
        gen_instr(4'd7, 0, 0, 0, 0, 0);
        gen_instr(4'd7, 0, 0, 0, 1, 0);
        gen_instr(4'd12, 1, 0, 0, -1, 0);
        gen_instr(4'd3, TIMEOUT, 0, 0, -1, 0);
        gen_instr(4'd6, 0, 1, 1, -1, 0);
        play(q.size());
        for (int i = 0; i < 150; i++) begin
            gen_instr(4'($urandom_range(0, 15)),
                      ($urandom_range(0, 7) == 0) ? 99 : int'($urandom_range(1, 6)),
                      $urandom_range(0, 3) == 0, $urandom_range(1, 4), -1,
                      $urandom_range(0, 7) == 0);
            play(q.size());
        end
        gen_instr(4'd4, 0, 0, 0, -1, 0);
        play(2);
        c = q.pop_front();
        en = c.en; mem_ready = c.mr; halt_req = c.hr; zero_flag = c.zf; opcode = c.op;
        #1 chk("exec_before_rst", outs, c.exp);
        rst = 1'b1;
        #1 chk("rst_async", outs, '0);
        q.delete();
        @(posedge clk); #1;
        chk("rst_edge", outs, '0);
        rst = 1'b0;
        push(1'b1, 1'b0, 1'b0, 1'b0, 4'd4, '0);
        gen_instr(4'd6, 0, 0, 0, -1, 0);
        play(q.size());
        en = 1'b0;
        en6 = 1'b1;
        opcode6 = 6'b000100;
        for (int i = 0; i < 9; i++) begin
            if (i == 4) opcode6 = 6'b010100;
            #1 chk($sformatf("w6_%0d", i), o6, w6_exp[i]);
            chk($sformatf("en_low_%0d", i), outs, '0);
            @(posedge clk); #1;
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
